// File: rtl/rx_bit_scheduler.sv
// USB receive bit-timing controller: finds packet start, tracks bit phase with
// edge resync, and strobes the datapath at mid-bit, byte end and end-of-packet.
module rx_bit_scheduler #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    output logic rcving,
    output logic shift_enable,
    output logic rx_bit,
    output logic byte_received,
    output logic eop,
    output logic byte_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_BYTE - 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, EOP_WAIT} state_t;

    state_t          state, state_nxt;
    logic            d_plus_prev;
    logic [CW-1:0]   clk_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            dp_edge, dp_fall, se0, line_j, sample_pt;

    assign dp_edge   = d_plus_sync != d_plus_prev;
    assign dp_fall   = d_plus_prev & ~d_plus_sync;
    assign se0       = ~d_plus_sync & ~d_minus_sync;
    assign line_j    = d_plus_sync & ~d_minus_sync;
    assign sample_pt = (state == RECEIVE) && (clk_cnt == SAMPLE_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (dp_fall)         state_nxt = RECEIVE;
            RECEIVE:  if (sample_pt && se0) state_nxt = EOP_WAIT;
            EOP_WAIT: if (line_j)          state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rcving       = state != IDLE;
        shift_enable = sample_pt && !se0;
    end

    // Any D+ edge restarts the bit phase; this wins over the normal wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_plus_prev   <= 1'b1;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            rx_bit        <= 1'b1;
            byte_received <= 1'b0;
            eop           <= 1'b0;
            byte_err      <= 1'b0;
        end else begin
            d_plus_prev   <= d_plus_sync;
            byte_received <= 1'b0;
            eop           <= 1'b0;
            byte_err      <= 1'b0;
            if (state != RECEIVE || dp_edge) clk_cnt <= '0;
            else if (clk_cnt == CNT_MAX)     clk_cnt <= '0;
            else                             clk_cnt <= clk_cnt + CW'(1);
            if (state != RECEIVE) begin
                bit_cnt <= '0;
            end else if (shift_enable) begin
                rx_bit <= d_plus_sync;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt       <= '0;
                    byte_received <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end else if (sample_pt) begin
                // SE0 at the sample point: end of packet, flag a partial byte.
                eop      <= 1'b1;
                byte_err <= bit_cnt != '0;
                bit_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rx_bit_scheduler.sv
// Randomized bench for rx_bit_scheduler against a timing model based on
// elapsed cycles since the last D+ edge.
module tb_rx_bit_scheduler;
    localparam int CPB = 8, SP = 3, BPB = 8;

    logic tb_clk = 1'b0;
    logic rst, d_plus_sync, d_minus_sync;
    logic rcving, shift_enable, rx_bit, byte_received, eop, byte_err;
    int   n_cmp = 0, n_bad = 0;

    always #5 tb_clk = ~tb_clk;

    rx_bit_scheduler #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .BITS_PER_BYTE(BPB)) dut (
        .clk(tb_clk), .rst(rst), .d_plus_sync(d_plus_sync), .d_minus_sync(d_minus_sync),
        .rcving(rcving), .shift_enable(shift_enable), .rx_bit(rx_bit),
        .byte_received(byte_received), .eop(eop), .byte_err(byte_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: packet phase plus the cycle of the last D+ edge.
    bit m_rx, m_eopw, m_prev, m_rxbit, m_byte, m_eop, m_err;
    int m_anchor, m_bits, t;
    int eop_seen, err_seen;
    int cnt;
    bit samp, s0, exp_sh, edg, fall;

    task automatic model_reset();
        m_rx = 0; m_eopw = 0; m_prev = 1; m_rxbit = 1;
        m_byte = 0; m_eop = 0; m_err = 0; m_anchor = 0; m_bits = 0;
    endtask

    always @(negedge tb_clk) begin
        if (rst) begin
            model_reset();
            chk("rst_rcving", rcving, 0);
            chk("rst_shift", shift_enable, 0);
            chk("rst_rx_bit", rx_bit, 1);
            chk("rst_eop", eop, 0);
        end else begin
            cnt    = m_rx ? (t - m_anchor - 1) % CPB : -1;
            samp   = m_rx && cnt == SP;
            s0     = !d_plus_sync && !d_minus_sync;
            exp_sh = samp && !s0;
            chk("rcving", rcving, m_rx || m_eopw);
            chk("shift_enable", shift_enable, exp_sh);
            chk("rx_bit", rx_bit, m_rxbit);
            chk("byte_received", byte_received, m_byte);
            chk("eop", eop, m_eop);
            chk("byte_err", byte_err, m_err);
            if (eop === 1'b1) eop_seen++;
            if (byte_err === 1'b1) err_seen++;
            m_byte = 0; m_eop = 0; m_err = 0;
            edg  = d_plus_sync != m_prev;
            fall = m_prev && !d_plus_sync;
            if (m_rx) begin
                if (exp_sh) begin
                    m_rxbit = d_plus_sync;
                    m_bits++;
                    if (m_bits == BPB) begin m_bits = 0; m_byte = 1; end
                end
                if (samp && s0) begin
                    m_eop = 1; m_err = m_bits != 0; m_bits = 0;
                    m_rx = 0; m_eopw = 1;
                end
                if (edg) m_anchor = t;
            end else if (m_eopw) begin
                if (d_plus_sync && !d_minus_sync) m_eopw = 0;
            end else if (fall) begin
                m_rx = 1; m_anchor = t; m_bits = 0;
            end
            m_prev = d_plus_sync;
        end
        t++;
    end

    task automatic hold(input logic p, input logic m, input int n);
        d_plus_sync = p; d_minus_sync = m;
        repeat (n) begin @(posedge tb_clk); #1; end
    endtask

    task automatic bit_period(input logic lvl, input int n);
        hold(lvl, ~lvl, n);
    endtask

    int lat1, lat2, nbits;
    logic lvl;

    initial begin
        t = 0; eop_seen = 0; err_seen = 0;
        rst = 1'b1; d_plus_sync = 1'b1; d_minus_sync = 1'b0;
        #22 rst = 1'b0;
        @(posedge tb_clk); #1;

        // Start latency, then alternating byte with one late transition
        hold(1, 0, 4);
        d_plus_sync = 0; d_minus_sync = 1;
        lat1 = -1; lat2 = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge tb_clk);
            if (shift_enable === 1'b1) begin
                if (lat1 < 0) lat1 = k; else if (lat2 < 0) lat2 = k;
            end
        end
        chk("first_strobe_lat", lat1, 4);
        chk("second_strobe_lat", lat2, 12);
        @(posedge tb_clk); #1;
        for (int i = 0; i < 14; i++) bit_period(i % 2 == 0, (i == 6) ? CPB + 2 : CPB);
        eop_seen = 0; err_seen = 0;
        hold(0, 0, 2 * CPB);
        hold(1, 0, 6);
        chk("clean_eop_count", eop_seen, 1);
        chk("clean_err_count", err_seen, 0);
        chk("clean_idle", rcving, 0);

        // Truncated packet then immediate restart
        eop_seen = 0; err_seen = 0;
        for (int i = 0; i < 5; i++) bit_period(i % 2 == 1, CPB);
        hold(0, 0, 2 * CPB);
        hold(1, 0, 4);
        chk("trunc_eop_count", eop_seen, 1);
        chk("trunc_err_count", err_seen, 1);
        for (int i = 0; i < 9; i++) bit_period(i % 2 == 1, CPB);
        hold(0, 0, 2 * CPB);
        hold(1, 0, 4);

        // Asynchronous reset in the middle of a packet
        bit_period(0, 20);
        @(negedge tb_clk); #2 rst = 1'b1;
        #1;
        chk("async_rcving", rcving, 0);
        chk("async_shift", shift_enable, 0);
        chk("async_rx_bit", rx_bit, 1);
        chk("async_byte", byte_received, 0);
        chk("async_eop", eop, 0);
        chk("async_err", byte_err, 0);
        d_plus_sync = 1; d_minus_sync = 0;
        #14 rst = 1'b0;
        hold(1, 0, 10);
        chk("post_rst_rcving", rcving, 0);

        // Random packets with jittered bit lengths
        repeat (30) begin
            hold(1, 0, $urandom_range(2, 10));
            nbits = $urandom_range(1, 24);
            for (int i = 0; i < nbits; i++) begin
                lvl = (i == 0) ? 1'b0 : 1'($urandom % 2);
                bit_period(lvl, CPB - 2 + $urandom_range(0, 4));
            end
            hold(0, 0, $urandom_range(2 * CPB, 2 * CPB + 4));
            hold(1, 0, $urandom_range(4, 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
